// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic MIPS pipeline stage register.
// Used by pipe_stage (optional skid build selected with PIPE_STAGE_SKID_EN).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CTRL_W = 9;
    localparam int PIPE_CNT_W  = 16;

    // Bit positions of the core control field carried in in_ctrl.
    localparam int CTRL_REG_DST    = 0;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_BRANCH     = 6;
    localparam int CTRL_ALU_OP_LO  = 7;
    localparam int CTRL_ALU_OP_HI  = 8;

    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
// Synchronous active-low reset.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline stage register with flush, bubble gating and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with registered in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = TWO;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over everything; any entry accepted this cycle is dropped.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= (state_d != TWO);
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (out_fire) begin
            state_d = EMPTY;
        end
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    // Control bits of a bubble must never reach the next stage.
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = state_occupancy(state_q);

    pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (out_valid & ~out_ready),
        .cnt_o  (stall_cnt)
    );

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Generic, parametrised pipeline stage register for the MIPS core, replacing the hand-written per-stage latches (ID/RR, RR/EX, EX/MEM, MEM/WB). It moves a payload word plus a control-bit field one stage forward per cycle under a valid/ready handshake. It supports back-pressure (stall), a synchronous flush for branch/jump squash and bubble gating of control bits. An optional skid entry makes `in_ready` fully registered. A saturating stall counter supports performance analysis.

## Interface
- `DATA_W`, 128: payload width (operands, immediate, register numbers, funct).
- `CTRL_W`, 9: control-bit width (MemRead, MemWrite, RegWrite, ALUOp, …); forced to zero whenever the stage holds a bubble.
- `CNT_W`, 16: stall counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  squash all stage contents this cycle.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  stage can accept an entry.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `out_valid`  out  1  stage holds a valid entry.
- `out_ready`  in  1  downstream accepts the entry.
- `out_data`  out  DATA_W  payload of the head entry.
- `out_ctrl`  out  CTRL_W  head control bits, zero when `out_valid`=0.
- `occupancy`  out  2  number of held entries (0–2).
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Transfers: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Storage: the main register is the head and drives `out_data` and `out_ctrl`. The skid register is the second entry.
- State machine (package enum): EMPTY, ONE, TWO.
  - EMPTY: on `in_fire`, go to ONE and load main.
  - ONE, `in_fire` & `out_fire`: stay in ONE and load main with the new entry.
  - ONE, `in_fire` & !`out_ready`: go to TWO and load skid.
  - ONE, `out_fire` & !`in_fire`: go to EMPTY.
  - TWO: on `out_fire`, go to ONE and copy skid into main. No input is accepted in TWO.
- `flush` has priority over every transition. The state goes to EMPTY and any same-cycle `in_fire` entry is discarded. A same-cycle `out_fire` still completes downstream.
- Derived outputs:
  - `out_valid` = state≠EMPTY.
  - `occupancy` = 0/1/2 for EMPTY/ONE/TWO.
  - `out_ctrl` = `out_valid` ? main_ctrl : 0.
- `stall_cnt`: increments when `out_valid` & !`out_ready`, and holds at all-ones. It is not cleared by `flush`.
- Reset values:
  - state EMPTY, `out_valid` 0, `occupancy` 0.
  - main, skid, `out_data` and `out_ctrl` all 0.
  - `stall_cnt` 0, `in_ready` 1.
- Inputs are ignored while `reset`=0.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N and can leave at edge N+1.
- Throughput: 1 entry per cycle while `out_ready`=1.
- `in_ready` (skid build) is registered: next `in_ready` = next state≠TWO. One stall cycle on `out_ready` causes no loss and no duplication.
- Order is strictly FIFO; there is no reordering or replay.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid build with registered `in_ready`, as described above.
- Not defined:
  - Single register; state TWO is unreachable and `occupancy` is at most 1.
  - `in_ready` = !`out_valid` | `out_ready`, combinational from `out_ready`.
  - Flush, bubble gating, `stall_cnt` and reset values are unchanged.

## Structure
- Package `pipe_pkg`:
  - `pipe_state_t` enum (EMPTY, ONE, TWO).
  - Default width constants for `DATA_W`, `CTRL_W` and `CNT_W`.
  - Core control-field bit-position constants used to pack `in_ctrl`.
- Sub-module `pipe_sat_counter`, parametrised by width, with inputs inc and synchronous active-low reset. It is used for `stall_cnt`.

## Test plan
- Reset then stream 4 entries with `out_ready`=1: outputs are `in_data` 0x1..0x4, one per cycle, 1-cycle latency, `occupancy`≤1, `stall_cnt`=0.
- Skid build, `out_ready` low for 3 cycles while `in_valid` is held high with 0xA, 0xB:
  - `occupancy` goes 1→2.
  - `in_ready` drops the cycle after the skid fills.
  - 0xA then 0xB emerge without loss.
  - `stall_cnt`=3.
- `flush` in TWO with `in_valid`=1 carrying 0xC: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and 0xC never appears.
- Bubble gating: `in_ctrl`=0x1FF is accepted and drained, then the stage is empty. `out_ctrl`=0 while `out_data` keeps its last value.
- Reset mid-stream with the stage in TWO: after one cycle at `reset`=0, all outputs are at reset values, including `stall_cnt`=0 and `in_ready`=1.
- Saturation with `CNT_W`=4: `out_ready` held low for 20 cycles with the stage full gives `stall_cnt`=15, with no wrap.
